// File: rtl/alignement_marker_rx.sv
// alignement_marker_rx
// Receive-side alignment marker handling for a 4-lane 40GBASE-R datapath.
// Each physical lane independently searches for the periodic alignment
// marker, confirms it one period later, then tracks it. Once a lane is
// locked, the marker blocks are removed from its output stream.
//
// Optional build macro: AM_BIP_CHECK_EN adds a per-lane BIP accumulator
// and the bip_err_o output.
//
// Ports:
//   clk, reset     - single clock, synchronous active-high reset
//   block_v_i      - blocks on all lanes valid this cycle
//   head_i/data_i  - per-lane sync header / payload, lane n at [n*W +: W]
//   block_v_o      - per-lane output valid, low for removed markers
//   head_o/data_o  - registered copy of the last valid input
//   marker_v_o     - matched marker seen at the expected position
//   am_lock_o      - per-lane lock
//   lane_id_o      - logical lane id per physical lane (2 bits each)
//   all_lock_o     - all lanes locked
//   bip_err_o      - (AM_BIP_CHECK_EN only) BIP mismatch, aligned with marker_v_o
//
// Handshake: block_v_i qualifies every input lane in the same cycle; there
// is no backpressure. Outputs appear exactly one cycle later, and
// block_v_o[n]/marker_v_o[n] are single-cycle qualifiers for that lane.
module alignement_marker_rx #(
    parameter int LANE_N     = 4,
    parameter int HEAD_W     = 2,
    parameter int DATA_W     = 64,
    parameter int AM_PERIOD  = 16384,
    parameter int AM_BAD_MAX = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       block_v_i,
    input  logic [LANE_N*HEAD_W-1:0]   head_i,
    input  logic [LANE_N*DATA_W-1:0]   data_i,
    output logic [LANE_N-1:0]          block_v_o,
    output logic [LANE_N*HEAD_W-1:0]   head_o,
    output logic [LANE_N*DATA_W-1:0]   data_o,
    output logic [LANE_N-1:0]          marker_v_o,
    output logic [LANE_N-1:0]          am_lock_o,
    output logic [LANE_N*2-1:0]        lane_id_o,
    output logic                       all_lock_o
`ifdef AM_BIP_CHECK_EN
    ,
    output logic [LANE_N-1:0]          bip_err_o
`endif
);

    localparam int CNT_W = $clog2(AM_PERIOD);
    localparam int BAD_W = $clog2(AM_BAD_MAX + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK2 = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Marker bytes M0,M1,M2 for logical lanes 0..3.
    function automatic logic [23:0] am_pat(input int k);
        case (k)
            0:       am_pat = 24'h907647;
            1:       am_pat = 24'hF0C4E6;
            2:       am_pat = 24'hC5659B;
            default: am_pat = 24'hA2793D;
        endcase
    endfunction

    // One hit bit per logical lane id; BIP bytes 3 and 7 are not compared.
    function automatic logic [3:0] am_hit(input logic [HEAD_W-1:0] h,
                                          input logic [DATA_W-1:0] d);
        logic [3:0]  r;
        logic [23:0] m;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            m = am_pat(k);
            r[k] = (h == HEAD_W'(2)) &&
                   (d[7:0]   == m[23:16]) && (d[15:8]  == m[15:8]) &&
                   (d[23:16] == m[7:0])   && (d[39:32] == ~m[23:16]) &&
                   (d[47:40] == ~m[15:8]) && (d[55:48] == ~m[7:0]);
        end
        return r;
    endfunction

`ifdef AM_BIP_CHECK_EN
    function automatic logic [7:0] bip_of(input logic [HEAD_W-1:0] h,
                                          input logic [DATA_W-1:0] d);
        logic [7:0] c;
        c = '0;
        for (int b = 0; b < DATA_W; b++) c[b % 8] = c[b % 8] ^ d[b];
        c[3] = c[3] ^ h[0];
        c[4] = c[4] ^ h[1];
        return c;
    endfunction
`endif

    logic [LANE_N*HEAD_W-1:0] head_q;
    logic [LANE_N*DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            data_q <= '0;
        end else if (block_v_i) begin
            head_q <= head_i;
            data_q <= data_i;
        end
    end

    assign head_o     = head_q;
    assign data_o     = data_q;
    assign all_lock_o = &am_lock_o;

    genvar n;
    generate
        for (n = 0; n < LANE_N; n++) begin : g_lane
            state_e              state_q, state_d;
            logic [1:0]          id_q, id_d;
            logic [CNT_W-1:0]    cnt_q, cnt_d;
            logic [BAD_W-1:0]    bad_q, bad_d;
            logic                blk_v_q, blk_v_d;
            logic                mrk_v_q, mrk_v_d;
            logic [HEAD_W-1:0]   lane_h;
            logic [DATA_W-1:0]   lane_d;
            logic [3:0]          hit;
            logic [1:0]          hit_id;
            logic                exp_pos;

            assign lane_h = head_i[n*HEAD_W +: HEAD_W];
            assign lane_d = data_i[n*DATA_W +: DATA_W];
            assign hit    = am_hit(lane_h, lane_d);

            // cnt_q holds the offset of the previous block from the anchor
            // marker, so the block arriving with cnt_q == AM_PERIOD-1 sits
            // exactly one period after it.
            assign exp_pos = (state_q != ST_SEARCH) &&
                             (cnt_q == CNT_W'(AM_PERIOD - 1));

            always_comb begin
                hit_id = 2'd0;
                for (int k = 3; k >= 0; k--) begin
                    if (hit[k]) hit_id = 2'(k);
                end
            end

            always_comb begin
                state_d = state_q;
                id_d    = id_q;
                cnt_d   = cnt_q;
                bad_d   = bad_q;
                blk_v_d = block_v_i;
                mrk_v_d = 1'b0;
                if (block_v_i) begin
                    case (state_q)
                        ST_SEARCH: begin
                            if (|hit) begin
                                id_d    = hit_id;
                                cnt_d   = '0;
                                state_d = ST_CHECK2;
                            end
                        end
                        ST_CHECK2: begin
                            if (exp_pos) begin
                                cnt_d = '0;
                                if (hit[id_q]) begin
                                    state_d = ST_LOCKED;
                                    bad_d   = '0;
                                    mrk_v_d = 1'b1;
                                end else begin
                                    state_d = ST_SEARCH;
                                end
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        ST_LOCKED: begin
                            if (exp_pos) begin
                                cnt_d   = '0;
                                // The expected slot is removed whether or not it matched.
                                blk_v_d = 1'b0;
                                if (hit[id_q]) begin
                                    bad_d   = '0;
                                    mrk_v_d = 1'b1;
                                end else begin
                                    bad_d = bad_q + 1'b1;
                                    if (bad_q == BAD_W'(AM_BAD_MAX - 1)) state_d = ST_SEARCH;
                                end
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        default: state_d = ST_SEARCH;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= ST_SEARCH;
                    id_q    <= '0;
                    cnt_q   <= '0;
                    bad_q   <= '0;
                    blk_v_q <= 1'b0;
                    mrk_v_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    id_q    <= id_d;
                    cnt_q   <= cnt_d;
                    bad_q   <= bad_d;
                    blk_v_q <= blk_v_d;
                    mrk_v_q <= mrk_v_d;
                end
            end

            assign block_v_o[n]        = blk_v_q;
            assign marker_v_o[n]       = mrk_v_q;
            assign am_lock_o[n]        = (state_q == ST_LOCKED);
            assign lane_id_o[n*2 +: 2] = id_q;

`ifdef AM_BIP_CHECK_EN
            logic [7:0] acc_q, acc_d;
            logic [7:0] contrib;
            logic       err_q, err_d;

            assign contrib = bip_of(lane_h, lane_d);

            // The accumulator restarts on the marker that anchors a search
            // and on every confirmed marker, so each check covers exactly
            // the blocks since the previous marker.
            always_comb begin
                acc_d = acc_q;
                err_d = 1'b0;
                if (block_v_i) begin
                    if ((state_q == ST_SEARCH) && (|hit)) begin
                        acc_d = contrib;
                    end else if (mrk_v_d) begin
                        err_d = (acc_q != lane_d[31:24]) ||
                                (lane_d[63:56] != ~lane_d[31:24]);
                        acc_d = contrib;
                    end else begin
                        acc_d = acc_q ^ contrib;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    acc_q <= '0;
                    err_q <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    err_q <= err_d;
                end
            end

            assign bip_err_o[n] = err_q;
`endif
        end
    endgenerate

endmodule
